alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//   Reservation station feeding the ALU. Holds issued ALU/branch/JALR ops,
//   snoops two result buses for missing operands, and dispatches one ready
//   op per cycle. Outputs are registered; the ALU samples them on the next edge.
//   Sits between the issue/decode stage and the ALU, and is cleared on
//   pipeline flush.
// PARAMETERS
//   RS_SIZE        8   number of entries (power of two, >= 2)
//   RS_TYPE_WIDTH  6   op type width (opaque here, passed through to ALU)
// PORTS
//   clk_in          in   1   clock
//   rst_n_in        in   1   reset, asynchronous, active-low
//   rdy_in          in   1   global enable; low = freeze all state
//   flush           in   1   mispredict flush (effective only with rdy_in)
//   issue_valid     in   1   new op this cycle
//   issue_type      in   RS_TYPE_WIDTH  op type
//   issue_rob_id    in   32  destination ROB tag
//   issue_qj_pend   in   1   operand j still waiting on issue_qj
//   issue_qj        in   32  ROB tag producing j
//   issue_vj        in   32  j value (valid when !issue_qj_pend)
//   issue_qk_pend / issue_qk / issue_vk   in 1/32/32   same for operand k
//   issue_imm       in   32  immediate
//   full            out  1   all entries busy (combinational from busy bits)
//   cdb0_valid, cdb0_rob_id, cdb0_value   in 1/32/32   ALU result bus
//   cdb1_valid, cdb1_rob_id, cdb1_value   in 1/32/32   load/store result bus
//   alu_en          out  1   dispatch valid (registered)
//   alu_rob_id, alu_data_j, alu_data_k, alu_imm   out 32 each
//   alu_type        out  RS_TYPE_WIDTH
// BEHAVIOUR
//   Reset (rst_n_in=0, async): all busy/pend bits 0; all outputs 0.
//   Entry fields: busy, type, rob_id, vj, vk, qj, qk, qj_pend, qk_pend, imm.
//   All updates occur on posedge clk_in only when rdy_in=1; otherwise hold.
//   flush && rdy_in: clear all busy bits and alu_en; ignore same-cycle issue.
//   Issue: if issue_valid && !full, write the lowest-index free entry. If
//     issue_valid && full, drop the op (issuer must check full).
//   Issue bypass: a pending operand whose tag matches a same-cycle valid CDB
//     is stored as ready with that CDB value (cdb0 has priority over cdb1).
//   Snoop: each busy entry with *_pend && tag==cdbX_rob_id && cdbX_valid
//     captures the value and clears pend. Both operands may resolve at once.
//   Ready: busy && !qj_pend && !qk_pend, evaluated on current registered state.
//     A value captured at edge E makes the entry ready for dispatch at E+1.
//   Dispatch: at each edge, pick the lowest-index ready entry. Load alu_*
//     from it, set alu_en=1, and clear its busy bit. If no entry is ready,
//     alu_en=0 and the other alu_* outputs hold their values.
//   Latency: issue with both operands ready at edge E -> alu_en=1 after E+1.
//   Freeing and issue in the same cycle: a freed entry becomes reusable at
//     the next edge. full does not see same-cycle frees (conservative).
//   type and imm pass through uninterpreted. For imm-form ops the issuer
//     sets qk_pend=0.
//   Throughput: 1 dispatch/cycle; occupancy <= RS_SIZE.
// TESTING
//   1 Reset mid-run: busy entries plus alu_en=1, then rst_n_in=0 between edges
//     -> alu_en=0 and full=0 immediately; no dispatch after release.
//   2 Issue rob 3, vj=5, vk=7, no pend -> next edge alu_en=1, rob_id=3,
//     j=5, k=7. Idle cycle after -> alu_en=0.
//   3 Issue rob 4 with qj=9 pend; 3 cycles later cdb1 rob 9 value 0x10
//     -> dispatch one edge after capture with data_j=0x10.
//   4 Issue with qk=2 pend while cdb0 broadcasts rob 2 value 0xAB in the same
//     cycle -> bypass captured; dispatch next edge with data_k=0xAB.
//   5 Fill 8 entries all pend on tag 1 -> full=1; 9th issue dropped. Broadcast
//     tag 1 -> 8 dispatches on consecutive edges in index order.
//   6 Flush with 5 busy entries -> next cycle full=0 and alu_en=0; CDB rob 1
//     afterwards causes no dispatch. rdy_in=0 for 3 cycles -> state frozen.

Source files
------------

// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: buffers issued ops, snoops two
// result buses for missing operands and dispatches one ready op per cycle.
module alu_rs #(
   parameter int unsigned RS_SIZE       = 8,
   parameter int unsigned RS_TYPE_WIDTH = 6
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [RS_TYPE_WIDTH-1:0] issue_type,
   input  logic [31:0]              issue_rob_id,
   input  logic                     issue_qj_pend,
   input  logic [31:0]              issue_qj,
   input  logic [31:0]              issue_vj,
   input  logic                     issue_qk_pend,
   input  logic [31:0]              issue_qk,
   input  logic [31:0]              issue_vk,
   input  logic [31:0]              issue_imm,
   output logic                     full,
   input  logic                     cdb0_valid,
   input  logic [31:0]              cdb0_rob_id,
   input  logic [31:0]              cdb0_value,
   input  logic                     cdb1_valid,
   input  logic [31:0]              cdb1_rob_id,
   input  logic [31:0]              cdb1_value,
   output logic                     alu_en,
   output logic [31:0]              alu_rob_id,
   output logic [31:0]              alu_data_j,
   output logic [31:0]              alu_data_k,
   output logic [31:0]              alu_imm,
   output logic [RS_TYPE_WIDTH-1:0] alu_type
);

   localparam int unsigned IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]       busy;
   logic [RS_SIZE-1:0]       qj_pend;
   logic [RS_SIZE-1:0]       qk_pend;
   logic [RS_TYPE_WIDTH-1:0] e_type [RS_SIZE];
   logic [31:0]              e_rob  [RS_SIZE];
   logic [31:0]              e_vj   [RS_SIZE];
   logic [31:0]              e_vk   [RS_SIZE];
   logic [31:0]              e_qj   [RS_SIZE];
   logic [31:0]              e_qk   [RS_SIZE];
   logic [31:0]              e_imm  [RS_SIZE];

   logic [32:0]              snp_j  [RS_SIZE];
   logic [32:0]              snp_k  [RS_SIZE];
   logic [32:0]              iss_j;
   logic [32:0]              iss_k;
   logic [RS_SIZE-1:0]       ready;
   logic [IW-1:0]            free_idx;
   logic [IW-1:0]            disp_idx;

   // Returns {still_pending, value}; cdb0 wins when both buses carry the tag.
   function automatic logic [32:0] resolve(input logic        pend,
                                           input logic [31:0] tag,
                                           input logic [31:0] val);
      logic [32:0] r;
      r = {pend, val};
      if (pend) begin
         if (cdb0_valid && tag == cdb0_rob_id)
            r = {1'b0, cdb0_value};
         else if (cdb1_valid && tag == cdb1_rob_id)
            r = {1'b0, cdb1_value};
      end
      return r;
   endfunction

   assign full  = &busy;
   assign ready = busy & ~qj_pend & ~qk_pend;

   always_comb begin
      free_idx = '0;
      disp_idx = '0;
      for (int unsigned i = RS_SIZE; i > 0; i--) begin
         if (!busy[i-1])  free_idx = IW'(i - 1);
         if (ready[i-1])  disp_idx = IW'(i - 1);
      end
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         snp_j[i] = resolve(qj_pend[i], e_qj[i], e_vj[i]);
         snp_k[i] = resolve(qk_pend[i], e_qk[i], e_vk[i]);
      end
      iss_j = resolve(issue_qj_pend, issue_qj, issue_vj);
      iss_k = resolve(issue_qk_pend, issue_qk, issue_vk);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy       <= '0;
         qj_pend    <= '0;
         qk_pend    <= '0;
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            e_type[i] <= '0;
            e_rob[i]  <= '0;
            e_vj[i]   <= '0;
            e_vk[i]   <= '0;
            e_qj[i]   <= '0;
            e_qk[i]   <= '0;
            e_imm[i]  <= '0;
         end
         alu_en     <= 1'b0;
         alu_rob_id <= '0;
         alu_data_j <= '0;
         alu_data_k <= '0;
         alu_imm    <= '0;
         alu_type   <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            busy   <= '0;
            alu_en <= 1'b0;
         end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (busy[i]) begin
                  {qj_pend[i], e_vj[i]} <= snp_j[i];
                  {qk_pend[i], e_vk[i]} <= snp_k[i];
               end
            end
            if (|ready) begin
               alu_en           <= 1'b1;
               alu_rob_id       <= e_rob[disp_idx];
               alu_data_j       <= e_vj[disp_idx];
               alu_data_k       <= e_vk[disp_idx];
               alu_imm          <= e_imm[disp_idx];
               alu_type         <= e_type[disp_idx];
               busy[disp_idx]   <= 1'b0;
            end else begin
               alu_en <= 1'b0;
            end
            // free_idx only names an idle slot, so it never collides with disp_idx.
            if (issue_valid && !full) begin
               busy[free_idx]                     <= 1'b1;
               e_type[free_idx]                   <= issue_type;
               e_rob[free_idx]                    <= issue_rob_id;
               e_qj[free_idx]                     <= issue_qj;
               e_qk[free_idx]                     <= issue_qk;
               e_imm[free_idx]                    <= issue_imm;
               {qj_pend[free_idx], e_vj[free_idx]} <= iss_j;
               {qk_pend[free_idx], e_vk[free_idx]} <= iss_k;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, compared every
// cycle against an entry-table reference model.
module tb_alu_rs;

   localparam int N  = 8;
   localparam int TW = 6;

   logic          clk_in = 1'b0;
   logic          rst_n_in, rdy_in, flush, issue_valid;
   logic [TW-1:0] issue_type;
   logic [31:0]   issue_rob_id, issue_qj, issue_vj, issue_qk, issue_vk, issue_imm;
   logic          issue_qj_pend, issue_qk_pend, full;
   logic          cdb0_valid, cdb1_valid;
   logic [31:0]   cdb0_rob_id, cdb0_value, cdb1_rob_id, cdb1_value;
   logic          alu_en;
   logic [31:0]   alu_rob_id, alu_data_j, alu_data_k, alu_imm;
   logic [TW-1:0] alu_type;

   alu_rs #(.RS_SIZE(N), .RS_TYPE_WIDTH(TW)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rob_id(issue_rob_id),
      .issue_qj_pend(issue_qj_pend), .issue_qj(issue_qj), .issue_vj(issue_vj),
      .issue_qk_pend(issue_qk_pend), .issue_qk(issue_qk), .issue_vk(issue_vk),
      .issue_imm(issue_imm), .full(full),
      .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
      .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
      .alu_en(alu_en), .alu_rob_id(alu_rob_id), .alu_data_j(alu_data_j),
      .alu_data_k(alu_data_k), .alu_imm(alu_imm), .alu_type(alu_type)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit            busy;
      logic [TW-1:0] typ;
      logic [31:0]   rob, vj, vk, qj, qk, imm;
      bit            pj, pk;
   } ent_t;

   ent_t          m [N];
   bit            m_en;
   logic [31:0]   m_rob, m_j, m_k, m_imm;
   logic [TW-1:0] m_type;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int occupancy();
      int c = 0;
      for (int i = 0; i < N; i++) if (m[i].busy) c++;
      return c;
   endfunction

   // A pending operand picks up a matching broadcast; cdb0 is consulted first.
   function automatic ent_t snoop(input ent_t e);
      ent_t r = e;
      if (r.pj) begin
         if (cdb0_valid && r.qj == cdb0_rob_id) begin r.vj = cdb0_value; r.pj = 0; end
         else if (cdb1_valid && r.qj == cdb1_rob_id) begin r.vj = cdb1_value; r.pj = 0; end
      end
      if (r.pk) begin
         if (cdb0_valid && r.qk == cdb0_rob_id) begin r.vk = cdb0_value; r.pk = 0; end
         else if (cdb1_valid && r.qk == cdb1_rob_id) begin r.vk = cdb1_value; r.pk = 0; end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m[i] = '{default: '0};
      m_en = 0; m_rob = '0; m_j = '0; m_k = '0; m_imm = '0; m_type = '0;
   endtask

   task automatic model_step();
      int   d = -1;
      int   f = -1;
      ent_t e;
      if (!rst_n_in || !rdy_in) return;
      if (flush) begin
         for (int i = 0; i < N; i++) m[i].busy = 0;
         m_en = 0;
         return;
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (m[i].busy && !m[i].pj && !m[i].pk) d = i;
         if (!m[i].busy) f = i;
      end
      if (d >= 0) begin
         m_en = 1; m_rob = m[d].rob; m_j = m[d].vj; m_k = m[d].vk;
         m_imm = m[d].imm; m_type = m[d].typ;
      end else begin
         m_en = 0;
      end
      for (int i = 0; i < N; i++) if (m[i].busy) m[i] = snoop(m[i]);
      if (d >= 0) m[d].busy = 0;
      if (issue_valid && f >= 0) begin
         e.busy = 1; e.typ = issue_type; e.rob = issue_rob_id; e.imm = issue_imm;
         e.qj = issue_qj; e.vj = issue_vj; e.pj = issue_qj_pend;
         e.qk = issue_qk; e.vk = issue_vk; e.pk = issue_qk_pend;
         m[f] = snoop(e);
      end
   endtask

   task automatic set_idle();
      rdy_in = 1; flush = 0; issue_valid = 0; issue_type = '0; issue_rob_id = '0;
      issue_qj_pend = 0; issue_qj = '0; issue_vj = '0;
      issue_qk_pend = 0; issue_qk = '0; issue_vk = '0; issue_imm = '0;
      cdb0_valid = 0; cdb0_rob_id = '0; cdb0_value = '0;
      cdb1_valid = 0; cdb1_rob_id = '0; cdb1_value = '0;
   endtask

   task automatic issue(input logic [31:0] rob, input bit pj, input logic [31:0] qj,
                        input logic [31:0] vj, input bit pk, input logic [31:0] qk,
                        input logic [31:0] vk, input logic [31:0] imm, input logic [TW-1:0] typ);
      issue_valid = 1; issue_rob_id = rob; issue_imm = imm; issue_type = typ;
      issue_qj_pend = pj; issue_qj = qj; issue_vj = vj;
      issue_qk_pend = pk; issue_qk = qk; issue_vk = vk;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
      check("alu_en",  {31'd0, alu_en}, {31'd0, m_en});
      check("alu_rob", alu_rob_id, m_rob);
      check("alu_j",   alu_data_j, m_j);
      check("alu_k",   alu_data_k, m_k);
      check("alu_imm", alu_imm, m_imm);
      check("alu_type", {26'd0, alu_type}, {26'd0, m_type});
      check("full",    {31'd0, full}, {31'd0, occupancy() == N});
      set_idle();
   endtask

   initial begin
      set_idle();
      rst_n_in = 0;
      model_reset();
      tick(); tick();
      check("rst_en", {31'd0, alu_en}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      rst_n_in = 1;
      tick();

      // Ready op: dispatch one edge after the issue edge, then idle.
      issue(3, 0, 0, 5, 0, 0, 7, 32'h11, 6'd2);
      tick();
      check("t2_en_early", {31'd0, alu_en}, 32'd0);
      tick();
      check("t2_en", {31'd0, alu_en}, 32'd1);
      check("t2_rob", alu_rob_id, 32'd3);
      check("t2_j", alu_data_j, 32'd5);
      check("t2_k", alu_data_k, 32'd7);
      tick();
      check("t2_idle", {31'd0, alu_en}, 32'd0);

      // Operand j arrives on cdb1 three cycles after issue.
      issue(4, 1, 9, 0, 0, 0, 32'h22, 0, 6'd1);
      tick(); tick(); tick();
      cdb1_valid = 1; cdb1_rob_id = 9; cdb1_value = 32'h10;
      tick();
      check("t3_wait", {31'd0, alu_en}, 32'd0);
      tick();
      check("t3_en", {31'd0, alu_en}, 32'd1);
      check("t3_rob", alu_rob_id, 32'd4);
      check("t3_j", alu_data_j, 32'h10);

      // Same-cycle bypass of operand k from cdb0.
      issue(5, 0, 0, 32'h1, 1, 2, 0, 0, 6'd3);
      cdb0_valid = 1; cdb0_rob_id = 2; cdb0_value = 32'hAB;
      tick();
      tick();
      check("t4_en", {31'd0, alu_en}, 32'd1);
      check("t4_k", alu_data_k, 32'hAB);

      // Fill, drop the ninth op, then drain in index order.
      for (int i = 0; i < N; i++) begin
         issue(10 + i, 1, 1, 0, 0, 0, i, 0, 6'd4);
         tick();
      end
      check("t5_full", {31'd0, full}, 32'd1);
      issue(99, 0, 0, 1, 0, 0, 2, 0, 6'd5);
      tick();
      tick();
      cdb0_valid = 1; cdb0_rob_id = 1; cdb0_value = 32'h55;
      tick();
      for (int i = 0; i < N; i++) begin
         tick();
         check("t5_drain_en", {31'd0, alu_en}, 32'd1);
         check("t5_drain_rob", alu_rob_id, 32'(10 + i));
      end
      tick();
      check("t5_end", {31'd0, alu_en}, 32'd0);

      // Flush drops pending work; later broadcast finds nothing.
      for (int i = 0; i < 5; i++) begin
         issue(40 + i, 1, 1, 0, 0, 0, 0, 0, 6'd6);
         tick();
      end
      flush = 1;
      tick();
      check("t6_full", {31'd0, full}, 32'd0);
      check("t6_en", {31'd0, alu_en}, 32'd0);
      cdb0_valid = 1; cdb0_rob_id = 1; cdb0_value = 32'h77;
      tick(); tick();
      check("t6_nodisp", {31'd0, alu_en}, 32'd0);

      // rdy_in low freezes a live dispatch and ignores issue.
      issue(20, 0, 0, 32'hA, 0, 0, 32'hB, 0, 6'd7);
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         rdy_in = 0;
         issue(21 + i, 0, 0, 1, 0, 0, 1, 0, 6'd8);
         tick();
         check("t6_frozen_rob", alu_rob_id, 32'd20);
      end
      tick();
      check("t6_after", {31'd0, alu_en}, 32'd0);

      // Mid-run asynchronous reset.
      for (int i = 0; i < N - 1; i++) begin
         issue(50 + i, 1, 3, 0, 0, 0, 0, 0, 6'd9);
         tick();
      end
      issue(30, 0, 0, 2, 0, 0, 4, 0, 6'd9);
      tick();
      tick();
      check("t1_pre_en", {31'd0, alu_en}, 32'd1);
      rst_n_in = 0;
      #1;
      model_reset();
      check("t1_rst_en", {31'd0, alu_en}, 32'd0);
      check("t1_rst_full", {31'd0, full}, 32'd0);
      tick();
      rst_n_in = 1;
      cdb0_valid = 1; cdb0_rob_id = 3; cdb0_value = 32'h9;
      tick(); tick();
      check("t1_nodisp", {31'd0, alu_en}, 32'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         flush  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 9) < 6)
            issue($urandom_range(0, 63), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                  $urandom, TW'($urandom));
         cdb0_valid = ($urandom_range(0, 9) < 4);
         cdb0_rob_id = $urandom_range(0, 7); cdb0_value = $urandom;
         cdb1_valid = ($urandom_range(0, 9) < 4);
         cdb1_rob_id = $urandom_range(0, 7); cdb1_value = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
